// File: rtl/bram_mem_wrap.sv
// bram_mem_wrap: block-RAM stand-in for the DDR command interface.
// Independent write and read channels, each a two-state FSM, share one
// simple dual-port RAM (read-first). Misaligned commands set a sticky flag
// but still execute with the address and length truncated to whole beats.
module bram_mem_wrap #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wstart,
    output logic                  wready,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [LEN_WIDTH-1:0]  wdata_len,
    input  logic                  wdata_vld,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rstart,
    output logic                  rready,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [LEN_WIDTH-1:0]  rdata_len,
    output logic                  rdata_vld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  cmd_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [LEN_WIDTH-1:0]  LMASK = LEN_WIDTH'(BYTES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // A command is misaligned if either address or length has sub-beat bits set.
    function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [LEN_WIDTH-1:0]  len);
        return ((addr & AMASK) != {ADDR_WIDTH{1'b0}}) || ((len & LMASK) != {LEN_WIDTH{1'b0}});
    endfunction

    // write channel state
    state_t                wstate_q, wstate_d;
    logic [MEM_AW-1:0]     widx_q, widx_d;
    logic [LEN_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic                  wr_done_q, wr_done_d;
    logic                  mem_we_s;
    logic                  w_accept_s;
    logic [LEN_WIDTH-1:0]  w_beats_s;

    // read channel state
    state_t                rstate_q, rstate_d;
    logic [MEM_AW-1:0]     ridx_q, ridx_d;
    logic [LEN_WIDTH-1:0]  rcnt_q, rcnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  rd_issue_s;
    logic                  r_accept_s;
    logic [LEN_WIDTH-1:0]  r_beats_s;

    logic                  rdata_vld_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  cmd_err_q, cmd_err_d;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    assign w_beats_s = wdata_len >> LB;
    assign r_beats_s = rdata_len >> LB;

    // Write FSM: latch command in IDLE, consume N data beats in BUSY.
    always_comb begin
        wstate_d   = wstate_q;
        widx_d     = widx_q;
        wcnt_d     = wcnt_q;
        wr_done_d  = 1'b0;
        mem_we_s   = 1'b0;
        w_accept_s = 1'b0;
        case (wstate_q)
            S_IDLE: begin
                if (wstart) begin
                    w_accept_s = 1'b1;
                    widx_d     = MEM_AW'(waddr >> LB);
                    wcnt_d     = w_beats_s;
                    if (w_beats_s == {LEN_WIDTH{1'b0}}) begin
                        wr_done_d = 1'b1;
                        wstate_d  = S_IDLE;
                    end else begin
                        wstate_d  = S_BUSY;
                    end
                end else begin
                    wstate_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (wdata_vld) begin
                    mem_we_s = 1'b1;
                    widx_d   = widx_q + MEM_AW'(1);
                    wcnt_d   = wcnt_q - LEN_WIDTH'(1);
                    if (wcnt_q == LEN_WIDTH'(1)) begin
                        wstate_d  = S_IDLE;
                        wr_done_d = 1'b1;
                    end else begin
                        wstate_d  = S_BUSY;
                    end
                end else begin
                    wstate_d = S_BUSY;
                end
            end
            default: begin
                wstate_d = S_IDLE;
            end
        endcase
    end

    // Read FSM: issue N gapless reads, then one drain cycle for the last beat.
    always_comb begin
        rstate_d   = rstate_q;
        ridx_d     = ridx_q;
        rcnt_d     = rcnt_q;
        rd_done_d  = 1'b0;
        rd_issue_s = 1'b0;
        r_accept_s = 1'b0;
        case (rstate_q)
            S_IDLE: begin
                if (rstart) begin
                    r_accept_s = 1'b1;
                    ridx_d     = MEM_AW'(raddr >> LB);
                    rcnt_d     = r_beats_s;
                    if (r_beats_s == {LEN_WIDTH{1'b0}}) begin
                        rd_done_d = 1'b1;
                        rstate_d  = S_IDLE;
                    end else begin
                        rstate_d  = S_BUSY;
                    end
                end else begin
                    rstate_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (rcnt_q != {LEN_WIDTH{1'b0}}) begin
                    rd_issue_s = 1'b1;
                    ridx_d     = ridx_q + MEM_AW'(1);
                    rcnt_d     = rcnt_q - LEN_WIDTH'(1);
                    rstate_d   = S_BUSY;
                end else begin
                    rstate_d   = S_IDLE;
                    rd_done_d  = 1'b1;
                end
            end
            default: begin
                rstate_d = S_IDLE;
            end
        endcase
    end

    // Sticky error: set by any accepted misaligned command on either channel.
    always_comb begin
        cmd_err_d = cmd_err_q;
        if ((w_accept_s && misaligned(waddr, wdata_len)) ||
            (r_accept_s && misaligned(raddr, rdata_len))) begin
            cmd_err_d = 1'b1;
        end else begin
            cmd_err_d = cmd_err_q;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q    <= S_IDLE;
            widx_q      <= {MEM_AW{1'b0}};
            wcnt_q      <= {LEN_WIDTH{1'b0}};
            wr_done_q   <= 1'b0;
            rstate_q    <= S_IDLE;
            ridx_q      <= {MEM_AW{1'b0}};
            rcnt_q      <= {LEN_WIDTH{1'b0}};
            rd_done_q   <= 1'b0;
            rdata_vld_q <= 1'b0;
            rdata_q     <= {DATA_WIDTH{1'b0}};
            cmd_err_q   <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            widx_q      <= widx_d;
            wcnt_q      <= wcnt_d;
            wr_done_q   <= wr_done_d;
            rstate_q    <= rstate_d;
            ridx_q      <= ridx_d;
            rcnt_q      <= rcnt_d;
            rd_done_q   <= rd_done_d;
            rdata_vld_q <= rd_issue_s;
            cmd_err_q   <= cmd_err_d;
            if (rd_issue_s) begin
                rdata_q <= mem_q[ridx_q];
            end
        end
    end

    // RAM write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[widx_q] <= wdata;
        end
    end

    assign wready    = (wstate_q == S_IDLE);
    assign rready    = (rstate_q == S_IDLE);
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign rdata_vld = rdata_vld_q;
    assign rdata     = rdata_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_bram_mem_wrap.sv
// Directed bench for bram_mem_wrap with a read-data scoreboard queue.
module tb_bram_mem_wrap;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wstart, wready, wdata_vld;
    logic [31:0] waddr, raddr;
    logic [15:0] wdata_len, rdata_len;
    logic [63:0] wdata, rdata;
    logic        rstart, rready, rdata_vld, wr_done, rd_done, cmd_err;

    int ntest = 0;
    int nfail = 0;

    logic [63:0] model [0:1023];
    logic [63:0] sb [$];
    logic [63:0] wq [$];

    bram_mem_wrap dut (
        .clk(clk), .rstn(rstn),
        .wstart(wstart), .wready(wready), .waddr(waddr), .wdata_len(wdata_len),
        .wdata_vld(wdata_vld), .wdata(wdata),
        .rstart(rstart), .rready(rready), .raddr(raddr), .rdata_len(rdata_len),
        .rdata_vld(rdata_vld), .rdata(rdata),
        .wr_done(wr_done), .rd_done(rd_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write command followed by beats from wq; optional gaps and a stray wstart while busy.
    task automatic do_write(input logic [31:0] addr, input logic [15:0] len,
                            input bit gap, input bit busy_start);
        int n;
        int idx;
        n   = int'(len >> 3);
        idx = int'((addr >> 3) & 32'h3FF);
        wstart = 1'b1; waddr = addr; wdata_len = len;
        wdata_vld = 1'b1; wdata = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        wstart = 1'b0; wdata_vld = 1'b0;
        if (n == 0) begin
            chk("w0_done", wr_done, 1'b1);
            chk("w0_ready", wready, 1'b1);
            tick();
            chk("w0_done_clr", wr_done, 1'b0);
            chk("w0_ready2", wready, 1'b1);
        end else begin
            chk("w_ready_drop", wready, 1'b0);
            for (int k = 0; k < n; k++) begin
                if (gap && k > 0) begin
                    if (busy_start && k == 1) begin
                        wstart = 1'b1; waddr = 32'h0000_0500; wdata_len = 16'd8;
                    end
                    tick();
                    wstart = 1'b0;
                    chk("w_gap_ready", wready, 1'b0);
                    chk("w_gap_done", wr_done, 1'b0);
                end
                wdata_vld = 1'b1; wdata = wq[k];
                model[(idx + k) % 1024] = wq[k];
                tick();
                wdata_vld = 1'b0;
                if (k < n - 1) begin
                    chk("w_mid_ready", wready, 1'b0);
                    chk("w_mid_done", wr_done, 1'b0);
                end else begin
                    chk("w_end_ready", wready, 1'b1);
                    chk("w_end_done", wr_done, 1'b1);
                end
            end
            tick();
            chk("w_done_once", wr_done, 1'b0);
            chk("w_ready_hold", wready, 1'b1);
        end
        wq.delete();
    endtask

    // Read command: expected beats pushed at issue, popped as rdata_vld appears.
    task automatic do_read(input logic [31:0] addr, input logic [15:0] len);
        int n;
        int idx;
        int done_c;
        logic [63:0] e;
        n      = int'(len >> 3);
        idx    = int'((addr >> 3) & 32'h3FF);
        done_c = (n == 0) ? 1 : n + 2;
        for (int k = 0; k < n; k++) sb.push_back(model[(idx + k) % 1024]);
        rstart = 1'b1; raddr = addr; rdata_len = len;
        tick();
        rstart = 1'b0;
        for (int c = 1; c <= done_c; c++) begin
            chk("r_vld", rdata_vld, (n > 0 && c >= 2 && c <= n + 1));
            if (n > 0 && c >= 2 && c <= n + 1) begin
                if (sb.size() == 0) begin
                    chk("r_sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("r_data", rdata, e);
                end
            end
            chk("r_done", rd_done, (c == done_c));
            chk("r_ready", rready, (c == done_c || n == 0));
            if (c < done_c) tick();
        end
        tick();
        chk("r_done_clr", rd_done, 1'b0);
        chk("r_sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] e;
        rstn = 1'b0;
        wstart = 1'b0; waddr = 32'd0; wdata_len = 16'd0; wdata_vld = 1'b0; wdata = 64'd0;
        rstart = 1'b0; raddr = 32'd0; rdata_len = 16'd0;
        tick(); tick();
        chk("rst_wready", wready, 1'b1);
        chk("rst_rready", rready, 1'b1);
        chk("rst_rvld", rdata_vld, 1'b0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wdone", wr_done, 1'b0);
        chk("rst_rdone", rd_done, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        rstn = 1'b1;
        tick();

        // write 8 beats at 0x100 and read them back
        for (int k = 1; k <= 8; k++) wq.push_back(64'(k));
        do_write(32'h100, 16'd64, 1'b0, 1'b0);
        do_read(32'h100, 16'd64);
        chk("err_clean", cmd_err, 1'b0);

        // gapped write with a stray wstart while busy
        for (int k = 0; k < 4; k++) wq.push_back(64'h11 + 64'(k));
        do_write(32'h200, 16'd32, 1'b1, 1'b1);
        do_read(32'h200, 16'd32);

        // zero-length commands
        do_write(32'h300, 16'd0, 1'b0, 1'b0);
        do_read(32'h000, 16'd0);
        chk("err_zero", cmd_err, 1'b0);

        // misaligned read: word 32 (0x104 truncates to 0x100)
        do_read(32'h104, 16'd8);
        chk("err_set", cmd_err, 1'b1);

        // wrap from word 1023 to word 0
        wq.push_back(64'hA); wq.push_back(64'hB);
        do_write(32'd8184, 16'd16, 1'b0, 1'b0);
        do_read(32'd8184, 16'd16);
        do_read(32'd0, 16'd8);
        chk("err_held", cmd_err, 1'b1);

        // simultaneous write and read of word 40: read returns old data
        wq.push_back(64'h55);
        do_write(32'd320, 16'd8, 1'b0, 1'b0);
        sb.push_back(64'h55);
        wstart = 1'b1; waddr = 32'd320; wdata_len = 16'd8;
        rstart = 1'b1; raddr = 32'd320; rdata_len = 16'd8;
        tick();
        wstart = 1'b0; rstart = 1'b0;
        wdata_vld = 1'b1; wdata = 64'h66;
        tick();
        wdata_vld = 1'b0;
        chk("sim_vld", rdata_vld, 1'b1);
        e = sb.pop_front();
        chk("sim_old", rdata, e);
        chk("sim_wdone", wr_done, 1'b1);
        tick();
        chk("sim_rdone", rd_done, 1'b1);
        chk("sim_hold", rdata, 64'h55);
        model[40] = 64'h66;
        do_read(32'd320, 16'd8);

        // reset during beat 3 of an 8-beat read
        for (int k = 0; k < 8; k++) wq.push_back(64'h100 + 64'(k));
        do_write(32'd800, 16'd64, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) sb.push_back(model[100 + k]);
        rstart = 1'b1; raddr = 32'd800; rdata_len = 16'd64;
        tick();
        rstart = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("rr_vld", rdata_vld, 1'b1);
            e = sb.pop_front();
            chk("rr_data", rdata, e);
        end
        rstn = 1'b0;
        #1;
        chk("rr_vld_drop", rdata_vld, 1'b0);
        chk("rr_ready", rready, 1'b1);
        chk("rr_err_clr", cmd_err, 1'b0);
        sb.delete();
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("rr_no_stale", rdata_vld, 1'b0);
            chk("rr_idle", rready, 1'b1);
        end
        do_read(32'd800, 16'd64);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/bram_mem_wrap.md
# bram_mem_wrap

On-chip block-RAM responder for the DDR command interface: it accepts the same write/read commands that `test_data_gen` issues to `ddr_wrap` (`wstart`/`wready`/`waddr`/`wdata_len`/`wdata_vld`/`wdata`, `rstart`/`rready`/`raddr`/`rdata_len`/`rdata_vld`/`rdata`) and serves them from an internal dual-port RAM. It replaces `ddr_wrap` in `ku_top` for bring-up and regression runs without DDR4. It also flags command-format errors that `ddr_wrap` would silently mis-handle.

## Interface
- DATA_WIDTH, 64, width of `wdata`/`rdata`; a power of two, at least 8.
- ADDR_WIDTH, 32, byte-address width.
- LEN_WIDTH, 16, byte-length width.
- MEM_AW, 10, log2 of RAM depth in words.

Ports:
- clk  in  1  clock; every port is synchronous to it.
- rstn  in  1  asynchronous active-low reset.
- wstart  in  1  write-command strobe.
- wready  out  1  write channel idle and able to accept a command.
- waddr  in  ADDR_WIDTH  write start byte address.
- wdata_len  in  LEN_WIDTH  write length in bytes.
- wdata_vld  in  1  write data beat valid.
- wdata  in  DATA_WIDTH  write data.
- rstart  in  1  read-command strobe.
- rready  out  1  read channel idle and able to accept a command.
- raddr  in  ADDR_WIDTH  read start byte address.
- rdata_len  in  LEN_WIDTH  read length in bytes.
- rdata_vld  out  1  read data beat valid.
- rdata  out  DATA_WIDTH  read data.
- wr_done  out  1  one-cycle pulse when a write command completes.
- rd_done  out  1  one-cycle pulse when a read command completes.
- cmd_err  out  1  sticky flag for a misaligned command; cleared only by reset.

## Operation
- Terms: B = DATA_WIDTH/8 (bytes per beat); word index = (addr >> log2 B) mod 2^MEM_AW; beat count N = len >> log2 B.
- The write and read channels are fully independent, each with a two-state FSM: IDLE and BUSY.
- **Write FSM**
  - IDLE, `wready`=1. `wstart`=1 latches the word index and N.
  - If N=0: stay IDLE and pulse `wr_done` next cycle.
  - Otherwise go to BUSY, `wready`=0.
  - BUSY: each cycle with `wdata_vld`=1 writes `wdata` at the current index and increments the index, wrapping modulo 2^MEM_AW. The beat counter decrements.
  - After the Nth beat: go to IDLE and pulse `wr_done`.
  - Ignored inputs: `wdata_vld` in IDLE (including the `wstart` cycle), and `wstart` in BUSY.
- **Read FSM**
  - IDLE, `rready`=1. `rstart`=1 latches index and N.
  - If N=0: pulse `rd_done` next cycle and stay IDLE.
  - Otherwise go to BUSY. BUSY issues one RAM read per cycle, with no gaps, until N reads have been issued.
  - The FSM stays BUSY until the last beat has left the output register.
  - Ignored input: `rstart` in BUSY.
- **RAM:** simple dual-port, one write port and one read port. Read-first: a same-cycle read and write to the same word returns the old data.
- **Errors:** any accepted command with `addr[log2 B-1:0]`≠0 or `len[log2 B-1:0]`≠0 sets `cmd_err`. The command still executes with truncated address and length.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- **Reset values:** `wready`=1, `rready`=1, `rdata_vld`=0, `rdata`=0, `wr_done`=0, `rd_done`=0, `cmd_err`=0. Both FSMs are in IDLE and all counters are 0.
- **Write**, command accepted at cycle T:
  - `wready`=0 from T+1.
  - If the final beat is at cycle U: the RAM is written at U, `wready`=1 and `wr_done`=1 at U+1.
  - With back-to-back data (U=T+N), the next `wstart` can be accepted at T+N+1.
- **Read**, command accepted at T:
  - `rready`=0 from T+1.
  - RAM reads are issued at T+1..T+N.
  - Beat k (0-based) appears with `rdata_vld`=1 at T+2+k, so latency is 2 cycles.
  - `rdata` holds its last value when `rdata_vld`=0.
  - Last beat at T+N+1; `rready`=1 and `rd_done`=1 at T+N+2.
- **Read data visibility:** data written at cycle U is visible to a read issued at U+1 or later.
- **Reset mid-operation:** asynchronous return to reset values. A partial write leaves the beats already written in RAM; a partial read is abandoned with no further `rdata_vld`.
- **Wrap-around:** the index wraps from 2^MEM_AW-1 to 0 within a single command, with no error.

## Test plan
- **Write then read back:** `waddr`=0x100, `wdata_len`=64, 8 consecutive beats 0x1..0x8. Then `raddr`=0x100, `rdata_len`=64. Required: `rdata_vld` at T+2..T+9 with data 0x1..0x8, `rd_done` at T+10, `cmd_err`=0.
- **Gapped write:** 4 beats with `wdata_vld` toggling every other cycle. Required: `wready` stays 0 until the cycle after beat 4; `wr_done` pulses exactly once; readback matches.
- **Zero length and misalignment:** `wdata_len`=0 gives `wr_done` next cycle with `wready` never dropping. `raddr`=0x104 gives `cmd_err`=1, held until reset.
- **Wrap:** `waddr`=(1023·8), `wdata_len`=16, data 0xA, 0xB. Required: word 1023=0xA and word 0=0xB; read of 16 bytes from word 1023 returns 0xA, 0xB.
- **Concurrency and protocol:**
  - A simultaneous `wstart` and `rstart` to the same word: the read returns the old value.
  - `wstart` pulsed while BUSY is ignored, with no extra `wr_done`.
- **Reset during a read:** deassert `rstn` at beat 3 of 8. Required: `rdata_vld`=0 immediately; after release `rready`=1 and no stale beats appear.
